// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and its stage registers.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_DMEM_WAIT  = 2'd1,
    ST_REDIR_PEND = 2'd2,
    ST_FAULT      = 2'd3
  } state_e;

  // Index of each stage register in the enable/flush vectors
  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;
  localparam int NUM_STG   = 4;

  localparam int REG_W  = 5;
  localparam int WAIT_W = 16;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load sitting in EX.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_reg_s,
  input  logic [REG_W-1:0] id_reg_t,
  input  logic             id_uses_s,
  input  logic             id_uses_t,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_reg_probe,
  output logic             load_use
);

  logic hitS;
  logic hitT;

  assign hitS = id_uses_s && (id_reg_s == ex_reg_probe);
  assign hitT = id_uses_t && (id_reg_t == ex_reg_probe);

  // Register 0 is hard-wired, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_reg_probe != '0) && (hitS || hitT);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, PC control, stall/flush statistics
// and a data-memory timeout fault.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_reg_s,
  input  logic [REG_W-1:0] id_reg_t,
  input  logic             id_uses_s,
  input  logic             id_uses_t,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_reg_probe,
  input  logic             mem_redirect,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             pc_sel,
  output logic             fault,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic                loadUse;
  logic                dStall;
  logic                dStallCyc;
  logic                redirAcc;
  logic                pcWe;
  logic                pcSel;
  logic [NUM_STG-1:0]  stgWe;
  logic [NUM_STG-1:0]  stgFlush;

  hazard_detect u_hazard_detect (
    .id_reg_s     (id_reg_s),
    .id_reg_t     (id_reg_t),
    .id_uses_s    (id_uses_s),
    .id_uses_t    (id_uses_t),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_probe (ex_reg_probe),
    .load_use     (loadUse)
  );

  assign dStall = mem_access && !dmem_ready;

  always_comb begin
    stgWe     = '1;
    stgFlush  = '0;
    pcWe      = 1'b1;
    pcSel     = 1'b0;
    state_d   = state_q;
    dStallCyc = 1'b0;
    redirAcc  = 1'b0;

    if (state_q == ST_FAULT) begin
      stgWe = '0;
      pcWe  = 1'b0;
    end else if (dStall) begin
      dStallCyc           = 1'b1;
      pcWe                = 1'b0;
      stgWe[STG_IFID]     = 1'b0;
      stgWe[STG_IDEX]     = 1'b0;
      stgWe[STG_EXMEM]    = 1'b0;
      stgFlush[STG_MEMWB] = 1'b1;
      if (wait_cnt_q == TIMEOUT_W) begin
        state_d = ST_FAULT;
      end else if (state_q == ST_REDIR_PEND) begin
        // Keep discarding the stale fetch until imem has answered it
        stgFlush[STG_IFID] = 1'b1;
        if (imem_ready) begin
          state_d = ST_DMEM_WAIT;
        end
      end else begin
        state_d = ST_DMEM_WAIT;
      end
    end else if (state_q == ST_REDIR_PEND) begin
      pcWe               = 1'b0;
      stgFlush[STG_IFID] = 1'b1;
      if (imem_ready) begin
        state_d = ST_RUN;
      end
    end else begin
      state_d = ST_RUN;
      if (mem_redirect) begin
        redirAcc            = 1'b1;
        pcSel               = 1'b1;
        stgFlush[STG_IFID]  = 1'b1;
        stgFlush[STG_IDEX]  = 1'b1;
        stgFlush[STG_EXMEM] = 1'b1;
        if (!imem_ready) begin
          state_d = ST_REDIR_PEND;
        end
      end else if (loadUse) begin
        pcWe               = 1'b0;
        stgWe[STG_IFID]    = 1'b0;
        stgFlush[STG_IDEX] = 1'b1;
      end else if (!imem_ready) begin
        pcWe               = 1'b0;
        stgFlush[STG_IFID] = 1'b1;
      end
    end

    // Reset holds every stage cleared and frozen
    if (!reset) begin
      stgWe    = '0;
      stgFlush = '1;
      pcWe     = 1'b0;
      pcSel    = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d  = dStallCyc ? (wait_cnt_q + WAIT_W'(1)) : '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pcWe && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (redirAcc && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_we       = pcWe;
  assign pc_sel      = pcSel;
  assign ifid_we     = stgWe[STG_IFID];
  assign idex_we     = stgWe[STG_IDEX];
  assign exmem_we    = stgWe[STG_EXMEM];
  assign memwb_we    = stgWe[STG_MEMWB];
  assign ifid_flush  = stgFlush[STG_IFID];
  assign idex_flush  = stgFlush[STG_IDEX];
  assign exmem_flush = stgFlush[STG_EXMEM];
  assign memwb_flush = stgFlush[STG_MEMWB];
  assign fault       = (state_q == ST_FAULT);
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl with TIMEOUT=3 and 4-bit statistics counters.
module tb_pipeline_ctrl;

  // Control bits: {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
  //                ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel, fault}
  localparam logic [10:0] C_RUN   = 11'b11111_0000_0_0;
  localparam logic [10:0] C_RST   = 11'b00000_1111_0_0;
  localparam logic [10:0] C_LU    = 11'b00111_0100_0_0;
  localparam logic [10:0] C_REDIR = 11'b11111_1110_1_0;
  localparam logic [10:0] C_ISTL  = 11'b01111_1000_0_0;
  localparam logic [10:0] C_DSTL  = 11'b00001_0001_0_0;
  localparam logic [10:0] C_FLT   = 11'b00000_0000_0_1;

  typedef struct {
    string       name;
    logic [10:0] ctl;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_reg_s = '0;
  logic [4:0] id_reg_t = '0;
  logic       id_uses_s = 1'b0;
  logic       id_uses_t = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_reg_probe = '0;
  logic       mem_redirect = 1'b0;
  logic       mem_access = 1'b0;
  logic       dmem_ready = 1'b1;
  logic       imem_ready = 1'b1;

  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic pc_sel, fault;
  logic [3:0] stall_count, flush_count;
  logic [10:0] actCtl;

  exp_t expQ[$];
  exp_t curExp;
  logic [3:0] expStall = '0;
  logic [3:0] expFlush = '0;
  int totalChecks = 0;
  int badChecks = 0;
  logic doneDriving = 1'b0;

  pipeline_ctrl #(.TIMEOUT(3), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_reg_s     (id_reg_s),
    .id_reg_t     (id_reg_t),
    .id_uses_s    (id_uses_s),
    .id_uses_t    (id_uses_t),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_probe (ex_reg_probe),
    .mem_redirect (mem_redirect),
    .mem_access   (mem_access),
    .dmem_ready   (dmem_ready),
    .imem_ready   (imem_ready),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .idex_we      (idex_we),
    .exmem_we     (exmem_we),
    .memwb_we     (memwb_we),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .pc_sel       (pc_sel),
    .fault        (fault),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  assign actCtl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel, fault};

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after a rising edge and queue the expected response
  task automatic applyStimulus(input string name, input logic memRd, input logic [4:0] probe,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesS, input logic usesT, input logic redir,
                               input logic memAcc, input logic dRdy, input logic iRdy,
                               input logic [10:0] expCtl);
    exp_t e;
    @(posedge clk);
    #1;
    ex_mem_read  = memRd;
    ex_reg_probe = probe;
    id_reg_s     = rs;
    id_reg_t     = rt;
    id_uses_s    = usesS;
    id_uses_t    = usesT;
    mem_redirect = redir;
    mem_access   = memAcc;
    dmem_ready   = dRdy;
    imem_ready   = iRdy;
    e.name = name;
    e.ctl  = expCtl;
    e.sc   = expStall;
    e.fc   = expFlush;
    expQ.push_back(e);
    if (!expCtl[10] && expStall != 4'hF) expStall = expStall + 4'd1;
    if (expCtl[1] && expFlush != 4'hF) expFlush = expFlush + 4'd1;
  endtask

  task automatic applyReset(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    ex_mem_read  = 1'b0;
    ex_reg_probe = '0;
    id_uses_s    = 1'b0;
    id_uses_t    = 1'b0;
    mem_redirect = 1'b0;
    mem_access   = 1'b0;
    dmem_ready   = 1'b1;
    imem_ready   = 1'b1;
    expStall = '0;
    expFlush = '0;
    e.name = name;
    e.ctl  = C_RST;
    e.sc   = '0;
    e.fc   = '0;
    expQ.push_back(e);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic checkOutput(input exp_t e);
    totalChecks++;
    if (actCtl !== e.ctl) begin
      badChecks++;
      $display("[TB] FAIL %s ctl: got %b want %b", e.name, actCtl, e.ctl);
    end
    totalChecks++;
    if (stall_count !== e.sc) begin
      badChecks++;
      $display("[TB] FAIL %s stall_count: got %0d want %0d", e.name, stall_count, e.sc);
    end
    totalChecks++;
    if (flush_count !== e.fc) begin
      badChecks++;
      $display("[TB] FAIL %s flush_count: got %0d want %0d", e.name, flush_count, e.fc);
    end
  endtask

  // Monitor: compare on every falling edge for which a response has been queued
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      curExp = expQ.pop_front();
      checkOutput(curExp);
    end else if (doneDriving) begin
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyReset("reset0");
    applyReset("reset1");
    releaseReset();
    //             name          rd probe rs     rt     uS uT rd ma dr ir  expected
    applyStimulus("idle",        0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 1, C_RUN);
    applyStimulus("lu_rt",       1, 5'd5, 5'd0,  5'd5,  0, 1, 0, 0, 1, 1, C_LU);
    applyStimulus("after_lu",    0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 1, C_RUN);
    applyStimulus("lu_r0",       1, 5'd0, 5'd0,  5'd0,  0, 1, 0, 0, 1, 1, C_RUN);
    applyStimulus("lu_rs",       1, 5'd7, 5'd7,  5'd3,  1, 0, 0, 0, 1, 1, C_LU);
    applyStimulus("lu_miss",     1, 5'd8, 5'd7,  5'd3,  1, 1, 0, 0, 1, 1, C_RUN);
    applyStimulus("lu_unused",   1, 5'd7, 5'd7,  5'd7,  0, 0, 0, 0, 1, 1, C_RUN);
    applyStimulus("redir",       0, 5'd0, 5'd0,  5'd0,  0, 0, 1, 0, 1, 1, C_REDIR);
    applyStimulus("after_redir", 0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 1, C_RUN);
    applyStimulus("istall",      0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 0, C_ISTL);
    applyStimulus("istall_lu",   1, 5'd9, 5'd9,  5'd0,  1, 0, 0, 0, 1, 0, C_LU);
    applyStimulus("redir_iwait", 0, 5'd0, 5'd0,  5'd0,  0, 0, 1, 0, 1, 0, C_REDIR);
    applyStimulus("rpend1",      0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 0, C_ISTL);
    applyStimulus("rpend2",      0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 0, C_ISTL);
    applyStimulus("rpend_done",  0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 1, C_ISTL);
    applyStimulus("back_run",    0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 1, C_RUN);
    applyStimulus("dwait_lu1",   1, 5'd4, 5'd4,  5'd0,  1, 0, 0, 1, 0, 1, C_DSTL);
    applyStimulus("dwait_lu2",   1, 5'd4, 5'd4,  5'd0,  1, 0, 0, 1, 0, 1, C_DSTL);
    applyStimulus("dwait_lu3",   1, 5'd4, 5'd4,  5'd0,  1, 0, 0, 1, 0, 1, C_DSTL);
    applyStimulus("dwait_done",  1, 5'd4, 5'd4,  5'd0,  1, 0, 0, 1, 1, 1, C_LU);
    applyStimulus("idle2",       0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 1, C_RUN);
    applyStimulus("tmo1",        0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 1, 0, 1, C_DSTL);
    applyStimulus("tmo2",        0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 1, 0, 1, C_DSTL);
    applyStimulus("tmo3",        0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 1, 0, 1, C_DSTL);
    applyStimulus("tmo4",        0, 5'd0, 5'd0,  5'd0,  0, 0, 1, 1, 0, 1, C_DSTL);
    applyStimulus("fault1",      0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 1, 0, 1, C_FLT);
    applyStimulus("fault2",      0, 5'd0, 5'd0,  5'd0,  0, 0, 1, 0, 1, 1, C_FLT);
    applyStimulus("fault_sat",   1, 5'd2, 5'd2,  5'd0,  1, 0, 0, 0, 1, 0, C_FLT);
    applyReset("reset_fault");
    releaseReset();
    applyStimulus("post_reset",  0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 1, C_RUN);
    applyStimulus("post_redir",  0, 5'd0, 5'd0,  5'd0,  0, 0, 1, 0, 1, 1, C_REDIR);
    applyStimulus("post_idle",   0, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 1, C_RUN);
    @(posedge clk);
    doneDriving = 1'b1;
  end

endmodule
